// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared types, widths and scan index helpers for mux_scan_serializer
package mux_scan_pkg;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 4;

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} state_t;

    function automatic logic [ADDR_W-1:0] start_index(input bit lsb_first);
        return lsb_first ? 2'd0 : 2'd3;
    endfunction

    function automatic logic [ADDR_W-1:0] end_index(input bit lsb_first);
        return lsb_first ? 2'd3 : 2'd0;
    endfunction
endpackage

// File: rtl/scan_addr_counter.sv
// rtl/scan_addr_counter.sv - 2-bit up/down select counter with load, enable and at_end flag
module scan_addr_counter
    import mux_scan_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              enable,
    output logic [ADDR_W-1:0] count,
    output logic              at_end
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= start_index(LSB_FIRST);
        end else if (load) begin
            count <= start_index(LSB_FIRST);
        end else if (enable) begin
            count <= LSB_FIRST ? count + 1'b1 : count - 1'b1;
        end
    end

    assign at_end = (count == end_index(LSB_FIRST));
endmodule

// File: rtl/mux_scan_serializer.sv
// rtl/mux_scan_serializer.sv - 4:1 mux select sequencer/serializer; optional parity beat via MUX_SCAN_PARITY_EN
module mux_scan_serializer
    import mux_scan_pkg::*;
#(
    parameter bit LSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] held_word,
    output logic              address0,
    output logic              address1,
    output logic              out_bit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy
);
    localparam state_t     AFTER_WORD = (GAP_CYCLES > 0) ? GAP : IDLE;
    localparam logic [3:0] GAP_LAST   = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t            state;
    logic [3:0]        gap_cnt;
    logic [ADDR_W-1:0] addr;
    logic              at_end;
    logic              accept;
    logic              step;

    assign accept = in_valid && (state == IDLE);
    // Only non-final data beats move the select; the last beat leaves it parked at the end index.
    assign step   = (state == SHIFT) && out_ready && !at_end;

    scan_addr_counter #(.LSB_FIRST(LSB_FIRST)) u_addr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .enable (step),
        .count  (addr),
        .at_end (at_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            held_word <= '0;
            gap_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        held_word <= in_data;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (out_ready && at_end) begin
`ifdef MUX_SCAN_PARITY_EN
                        state <= PARITY;
`else
                        state <= AFTER_WORD;
`endif
                    end
                end
                PARITY: begin
                    if (out_ready) state <= AFTER_WORD;
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == SHIFT) || (state == PARITY);
    assign address0  = addr[0];
    assign address1  = addr[1];
    assign out_bit   = (state == PARITY) ? ^held_word :
                       (state == SHIFT)  ? held_word[addr] : 1'b0;
`ifdef MUX_SCAN_PARITY_EN
    assign out_last  = (state == PARITY);
`else
    assign out_last  = (state == SHIFT) && at_end;
`endif
endmodule

// File: tb/tb_mux_scan_serializer.sv
// tb/tb_mux_scan_serializer.sv - randomized self-checking bench for mux_scan_serializer (three parameterizations)
module tb_mux_scan_serializer;
`ifdef MUX_SCAN_PARITY_EN
    localparam int NBEATS = 5;
`else
    localparam int NBEATS = 4;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic out_ready = 1'b0;

    // dut 0: LSB first, no gap; dut 1: MSB first, no gap; dut 2: LSB first, 2 gap cycles
    logic [2:0] ir, ov, ol, ob, a0, a1, bz;
    logic [2:0][3:0] hw;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_scan_serializer #(.LSB_FIRST(1'b1), .GAP_CYCLES(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .held_word(hw[0]), .address0(a0[0]), .address1(a1[0]), .out_bit(ob[0]),
        .out_valid(ov[0]), .out_ready(out_ready), .out_last(ol[0]), .busy(bz[0]));
    mux_scan_serializer #(.LSB_FIRST(1'b0), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .held_word(hw[1]), .address0(a0[1]), .address1(a1[1]), .out_bit(ob[1]),
        .out_valid(ov[1]), .out_ready(out_ready), .out_last(ol[1]), .busy(bz[1]));
    mux_scan_serializer #(.LSB_FIRST(1'b1), .GAP_CYCLES(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
        .held_word(hw[2]), .address0(a0[2]), .address1(a1[2]), .out_bit(ob[2]),
        .out_valid(ov[2]), .out_ready(out_ready), .out_last(ol[2]), .busy(bz[2]));

    function automatic logic [1:0] exp_addr(input int i, input int k);
        int kk;
        kk = (k > 3) ? 3 : k;
        return (i == 1) ? 2'(3 - kk) : 2'(kk);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (ir !== 3'b111 && guard < 50) begin
            step();
            guard++;
        end
        checks++;
        if (ir !== 3'b111) begin
            failures++;
            $display("FAIL wait_idle in_ready got=%b exp=111", ir);
        end
    endtask

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < 3; i++) begin
            checks += 6;
            if (ir[i] !== 1'b1) begin failures++; $display("FAIL %s in_ready dut%0d got=%b exp=1", tag, i, ir[i]); end
            if (ov[i] !== 1'b0 || ob[i] !== 1'b0) begin failures++; $display("FAIL %s out_valid/out_bit dut%0d got=%b%b exp=00", tag, i, ov[i], ob[i]); end
            if (ol[i] !== 1'b0) begin failures++; $display("FAIL %s out_last dut%0d got=%b exp=0", tag, i, ol[i]); end
            if (bz[i] !== 1'b0) begin failures++; $display("FAIL %s busy dut%0d got=%b exp=0", tag, i, bz[i]); end
            if (hw[i] !== 4'h0) begin failures++; $display("FAIL %s held_word dut%0d got=%h exp=0", tag, i, hw[i]); end
            if ({a1[i], a0[i]} !== exp_addr(i, 0)) begin failures++; $display("FAIL %s address dut%0d got=%0d exp=%0d", tag, i, {a1[i], a0[i]}, exp_addr(i, 0)); end
        end
    endtask

    // Serialises one word on all three DUTs and checks every cycle against the beat model.
    task automatic run_word(input logic [3:0] w, input int stall_pct, input int stall_beat, input int stall_len);
        int k = 0;
        int stalled = 0;
        int guard = 0;
        logic [1:0] ea;
        logic eb;
        wait_idle();
        in_valid = 1'b1;
        in_data = w;
        out_ready = 1'b0;
        step();
        while (k < NBEATS && guard < 200) begin
            guard++;
            if (k == stall_beat && stalled < stall_len) begin
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = ($urandom_range(99) >= stall_pct);
            end
            in_valid = (k == NBEATS - 1 && out_ready) ? 1'b0 : 1'($urandom_range(1));
            in_data = 4'($urandom);
            for (int i = 0; i < 3; i++) begin
                ea = exp_addr(i, k);
                eb = (k < 4) ? w[ea] : ^w;
                checks += 6;
                if (ov[i] !== 1'b1) begin failures++; $display("FAIL beat_valid dut%0d beat%0d got=%b exp=1", i, k, ov[i]); end
                if ({a1[i], a0[i]} !== ea) begin failures++; $display("FAIL beat_address dut%0d beat%0d got=%0d exp=%0d", i, k, {a1[i], a0[i]}, ea); end
                if (ob[i] !== eb) begin failures++; $display("FAIL beat_bit dut%0d beat%0d word=%h got=%b exp=%b", i, k, w, ob[i], eb); end
                if (ol[i] !== (k == NBEATS - 1)) begin failures++; $display("FAIL beat_last dut%0d beat%0d got=%b exp=%b", i, k, ol[i], k == NBEATS - 1); end
                if (hw[i] !== w) begin failures++; $display("FAIL beat_held dut%0d beat%0d got=%h exp=%h", i, k, hw[i], w); end
                if (ir[i] !== 1'b0 || bz[i] !== 1'b1) begin failures++; $display("FAIL beat_busy dut%0d beat%0d got=%b%b exp=01", i, k, ir[i], bz[i]); end
            end
            step();
            if (out_ready) k++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (k != NBEATS) begin failures++; $display("FAIL word_timeout beats got=%0d exp=%0d", k, NBEATS); end
        for (int i = 0; i < 3; i++) begin
            checks += 2;
            if (ir[i] !== (i != 2)) begin failures++; $display("FAIL post_word_in_ready dut%0d got=%b exp=%b", i, ir[i], i != 2); end
            if (ov[i] !== 1'b0 || ob[i] !== 1'b0) begin failures++; $display("FAIL post_word_valid dut%0d got=%b%b exp=00", i, ov[i], ob[i]); end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        check_reset_values("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_reset_values("reset_release");
    endtask

    task automatic test_lsb_msb();
        run_word(4'b1011, 0, -1, 0);
        run_word(4'b1000, 0, -1, 0);
    endtask

    task automatic test_stall();
        run_word(4'b0110, 0, 1, 3);
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            run_word(4'($urandom), $urandom_range(60), -1, 0);
        end
    endtask

    task automatic test_back_to_back();
        wait_idle();
        in_valid = 1'b1;
        in_data = 4'hA;
        out_ready = 1'b1;
        step();
        in_data = 4'h5;
        repeat (NBEATS) step();
        checks += 4;
        if (ir[1:0] !== 2'b11) begin failures++; $display("FAIL b2b_ready_ab got=%b exp=11", ir[1:0]); end
        if (hw[0] !== 4'hA || hw[1] !== 4'hA) begin failures++; $display("FAIL b2b_no_same_cycle_accept got=%h/%h exp=a/a", hw[0], hw[1]); end
        if (ir[2] !== 1'b0 || ov[2] !== 1'b0) begin failures++; $display("FAIL b2b_gap1 dut2 got=%b%b exp=00", ir[2], ov[2]); end
        if (bz[2] !== 1'b1) begin failures++; $display("FAIL b2b_gap1_busy dut2 got=%b exp=1", bz[2]); end
        step();
        checks += 3;
        if (hw[0] !== 4'h5 || ov[0] !== 1'b1) begin failures++; $display("FAIL b2b_accept_a got=%h/%b exp=5/1", hw[0], ov[0]); end
        if (ir[2] !== 1'b0) begin failures++; $display("FAIL b2b_gap2 dut2 got=%b exp=0", ir[2]); end
        if (hw[2] !== 4'hA) begin failures++; $display("FAIL b2b_held_gap dut2 got=%h exp=a", hw[2]); end
        step();
        checks++;
        if (ir[2] !== 1'b1) begin failures++; $display("FAIL b2b_ready_after_gap dut2 got=%b exp=1", ir[2]); end
        step();
        in_valid = 1'b0;
        checks += 3;
        if (hw[2] !== 4'h5) begin failures++; $display("FAIL b2b_accept_c got=%h exp=5", hw[2]); end
        if (ov[2] !== 1'b1 || ob[2] !== 1'b1) begin failures++; $display("FAIL b2b_first_beat_c got=%b%b exp=11", ov[2], ob[2]); end
        if ({a1[2], a0[2]} !== 2'd0) begin failures++; $display("FAIL b2b_addr_c got=%0d exp=0", {a1[2], a0[2]}); end
        wait_idle();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_word();
        wait_idle();
        in_valid = 1'b1;
        in_data = 4'b1101;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        checks++;
        if (ov !== 3'b111) begin failures++; $display("FAIL midreset_pre_valid got=%b exp=111", ov); end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset_async");
        #2;
        rst_n = 1'b1;
        out_ready = 1'b0;
        run_word(4'b0011, 20, -1, 0);
    endtask

    initial begin
        test_reset();
        test_lsb_msb();
        test_stall();
        test_back_to_back();
        test_reset_mid_word();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
